muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. It accepts one M-extension operation from the execute stage, computes it over a fixed number of cycles, and presents the 32-bit result to the writeback result-select multiplexer as its mul/div input channel. The pipeline stalls on `in_ready`/`out_valid`.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 66 ++++++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type and operand-sign decode helpers.
package muldiv_pkg;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } muldiv_state_t;

   function automatic logic a_is_signed(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Per-iteration datapath: radix-2 shift-add multiplier and restoring divider
// running in lockstep on unsigned magnitudes, plus the shared iteration counter.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clear,
   input  logic               i_step,
   input  logic [WIDTH-1:0]   i_abs_a,
   input  logic [WIDTH-1:0]   i_abs_b,
   output logic               o_last,
   output logic [2*WIDTH-1:0] o_prod,
   output logic [WIDTH-1:0]   o_quo,
   output logic [WIDTH-1:0]   o_rem
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_mcand;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH+1:0]   w_shift;
   logic [WIDTH+1:0]   w_diff;

   // Multiplier sits in the low half of r_prod and is consumed LSB-first.
   assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
   // Dividend sits in r_quo and is consumed MSB-first; a set borrow bit means restore.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_diff  = w_shift - {2'b00, r_mcand};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_prod  <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_mcand <= '0;
      end else if (i_clear) begin
         r_cnt   <= '0;
         r_prod  <= {{WIDTH{1'b0}}, i_abs_a};
         r_quo   <= i_abs_a;
         r_rem   <= '0;
         r_mcand <= i_abs_b;
      end else if (i_step) begin
         r_cnt   <= r_cnt + CNT_W'(1);
         r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
         r_rem   <= w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
         r_quo   <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH+1]};
      end
   end

   assign o_last = (r_cnt == CNT_W'(WIDTH - 1));
   assign o_prod = r_prod;
   assign o_quo  = r_quo;
   assign o_rem  = r_rem[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling, special cases and
// result select around the muldiv_iter datapath. Fixed latency for every op.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   muldiv_state_t    r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;

   logic               w_sign_a;
   logic               w_sign_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic               w_last;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0]   w_quo_s;
   logic [WIDTH-1:0]   w_rem_s;
   logic               w_div_zero;
   logic               w_overflow;
   logic [WIDTH-1:0]   w_fix_result;

   assign w_sign_a = a_is_signed(r_op) & r_a[WIDTH-1];
   assign w_sign_b = b_is_signed(r_op) & r_b[WIDTH-1];
   assign w_abs_a  = w_sign_a ? -r_a : r_a;
   assign w_abs_b  = w_sign_b ? -r_b : r_b;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (r_state == ST_PREP),
      .i_step  (r_state == ST_CALC),
      .i_abs_a (w_abs_a),
      .i_abs_b (w_abs_b),
      .o_last  (w_last),
      .o_prod  (w_prod),
      .o_quo   (w_quo),
      .o_rem   (w_rem)
   );

   assign w_prod_s   = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
   assign w_quo_s    = (r_sign_a ^ r_sign_b) ? -w_quo : w_quo;
   assign w_rem_s    = r_sign_a ? -w_rem : w_rem;
   assign w_div_zero = (r_b == '0);
   assign w_overflow = ((r_op == MD_DIV) || (r_op == MD_REM)) && (r_a == MIN_NEG) && (r_b == '1);

   // NOTE: the default assignment ahead of the case keeps this purely
   // combinational; without it an unlisted path would infer a latch.
   always_comb begin
      w_fix_result = w_prod_s[WIDTH-1:0];
      case (r_op)
         MD_MUL:                        w_fix_result = w_prod_s[WIDTH-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  w_fix_result = w_prod_s[2*WIDTH-1:WIDTH];
         MD_DIV, MD_DIVU:
            if (w_div_zero)      w_fix_result = '1;
            else if (w_overflow) w_fix_result = MIN_NEG;
            else                 w_fix_result = w_quo_s;
         MD_REM, MD_REMU:
            if (w_div_zero)      w_fix_result = r_a;
            else if (w_overflow) w_fix_result = '0;
            else                 w_fix_result = w_rem_s;
         default:                       w_fix_result = w_prod_s[WIDTH-1:0];
      endcase
   end

   // Flush outranks every state transition, including acceptance and consumption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sign_a    <= 1'b0;
         r_sign_b    <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
      end else if (flush) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_op    <= op;
                  r_a     <= operand_a;
                  r_b     <= operand_b;
                  r_state <= ST_PREP;
               end
            end
            ST_PREP: begin
               r_sign_a <= w_sign_a;
               r_sign_b <= w_sign_b;
               r_state  <= ST_CALC;
            end
            ST_CALC: begin
               if (w_last) r_state <= ST_FIX;
            end
            ST_FIX: begin
               r_result    <= w_fix_result;
               r_out_valid <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results and latency, plus
// hand sequences for backpressure, flush and asynchronous reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W   = 32;
   localparam int LAT = 35;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;
   logic         out_ready = 1'b0;
   logic [2:0]   op = '0;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [W-1:0] result;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[18];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Caller is mid-cycle; request is accepted at the next rising edge.
   task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      op        = o;
      operand_a = a;
      operand_b = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Cycle 1 is the first cycle after the accepting edge; bounded at 100.
   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      @(negedge clk);
      check({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      start_op(v.op, v.a, v.b);
      wait_valid(lat);
      check({v.name, "_latency"}, lat, LAT);
      check({v.name, "_result"}, result, v.exp);
      consume();
   endtask

   initial begin
      int lat;
      logic ok;

      vecs[0]  = '{"mul_7xm3",      MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{"mul_m3xm3",     MD_MUL,    32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0000_0009};
      vecs[2]  = '{"mulh_min_min",  MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[3]  = '{"mulh_m3x5",     MD_MULH,   32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF};
      vecs[4]  = '{"mulhu_max",     MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[5]  = '{"mulhsu_m1x2",   MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[6]  = '{"div_m7_2",      MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
      vecs[7]  = '{"rem_m7_2",      MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[8]  = '{"div_m7_m2",     MD_DIV,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003};
      vecs[9]  = '{"divu_100_7",    MD_DIVU,   32'd100,       32'd7,         32'd14};
      vecs[10] = '{"remu_100_7",    MD_REMU,   32'd100,       32'd7,         32'd2};
      vecs[11] = '{"div_5_0",       MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF};
      vecs[12] = '{"divu_5_0",      MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
      vecs[13] = '{"rem_5_0",       MD_REM,    32'd5,         32'd0,         32'd5};
      vecs[14] = '{"remu_big_0",    MD_REMU,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0};
      vecs[15] = '{"div_ovf",       MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[16] = '{"rem_ovf",       MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[17] = '{"divu_max_3",    MD_DIVU,   32'hFFFF_FFFF, 32'd3,         32'h5555_5555};

      repeat (2) @(negedge clk);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result",    result,             32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) run_vec(vecs[i]);

      // Backpressure: result held for 10 cycles, then back-to-back issue.
      @(negedge clk);
      start_op(MD_DIVU, 32'd100, 32'd7);
      wait_valid(lat);
      check("bp_latency", lat, LAT);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!(out_valid === 1'b1 && in_ready === 1'b0 && result === 32'd14)) ok = 1'b0;
      end
      check("bp_hold_stable", {31'd0, ok}, 32'd1);
      consume();
      check("bp_in_ready_next", {31'd0, in_ready}, 32'd1);
      check("bp_out_valid_drop", {31'd0, out_valid}, 32'd0);
      start_op(MD_MUL, 32'd3, 32'd4);
      wait_valid(lat);
      check("b2b_latency", lat, LAT);
      check("b2b_result", result, 32'd12);
      consume();

      // Flush during cycle 12 of a DIV.
      @(negedge clk);
      start_op(MD_DIV, 32'd1000, 32'd3);
      repeat (11) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_calc_in_ready", {31'd0, in_ready}, 32'd1);
      check("flush_calc_busy", {31'd0, busy}, 32'd0);
      ok = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      check("flush_calc_no_valid", {31'd0, ok}, 32'd0);
      check("flush_calc_result_kept", result, 32'd12);

      // Flush beats a simultaneous request in IDLE.
      @(negedge clk);
      op = MD_MUL; operand_a = 32'd2; operand_b = 32'd2;
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check("flush_idle_busy", {31'd0, busy}, 32'd0);
      check("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Flush together with out_ready in DONE.
      @(negedge clk);
      start_op(MD_DIVU, 32'd100, 32'd7);
      wait_valid(lat);
      check("flush_done_latency", lat, LAT);
      out_ready = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_done_in_ready", {31'd0, in_ready}, 32'd1);
      check("flush_done_result", result, 32'd14);

      // Asynchronous reset mid-CALC, observed before any clock edge.
      @(negedge clk);
      start_op(MD_MUL, 32'd5, 32'd6);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_in_ready",  {31'd0, in_ready},  32'd1);
      check("arst_busy",      {31'd0, busy},      32'd0);
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_result",    result,             32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec('{"post_rst_mul", MD_MUL, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
